deck_dealer: RTL

Sequential reader of the shuffled deck RAM: after the shuffler signals completion, it serves single-card draw requests in deck order. For each card it returns the 6-bit card code, its blackjack value and an ace flag. It tracks the remaining cards and requests a reshuffle when the deck is exhausted. It sits between the deck memory and the game-control FSM (player and dealer hands).

---
 rtl/deck_pkg.sv | 26 ++
 rtl/card_value_lut.sv | 37 +++
 rtl/deck_dealer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/deck_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : deck_pkg
//  Brief    : Shared deck constants, dealer FSM state encoding and the
//             card-code range check used by the dealer and the shuffler.
//  Revision : 1.0 - initial release
// ============================================================================
package deck_pkg;

    localparam int DECK_SIZE = 52;
    localparam int CARD_W    = 6;
    localparam int RANKS     = 13;

    // Dealer FSM state encoding
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_READ    = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    // True when the code names a real card (0..DECK_SIZE-1)
    function automatic logic card_in_range(input logic [CARD_W-1:0] code);
        return (code < CARD_W'(DECK_SIZE));
    endfunction

endpackage
`default_nettype wire

// File: rtl/card_value_lut.sv
`default_nettype none
// ============================================================================
//  Module   : card_value_lut
//  Brief    : Combinational card code -> blackjack value and ace flag.
//             Out-of-range codes map to value 0, not an ace.
//  Revision : 1.0 - initial release
// ============================================================================
module card_value_lut
    import deck_pkg::*;
(
    input  logic [CARD_W-1:0] i_code,
    output logic [3:0]        o_value,
    output logic              o_is_ace
);

    logic [CARD_W-1:0] w_rank;

    assign w_rank = i_code % CARD_W'(RANKS);

    // Rank 0 is the ace (1), ranks 1..9 are pip cards, 10..12 are faces (10)
    always_comb begin
        o_value  = 4'd0;
        o_is_ace = 1'b0;
        if (card_in_range(i_code)) begin
            o_is_ace = (w_rank == '0);
            if (w_rank == '0) begin
                o_value = 4'd1;
            end else if (w_rank <= CARD_W'(9)) begin
                o_value = w_rank[3:0] + 4'd1;
            end else begin
                o_value = 4'd10;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/deck_dealer.sv
`default_nettype none
// ============================================================================
//  Module   : deck_dealer
//  Brief    : Sequential reader of the shuffled deck RAM. Serves one-card
//             draw requests in deck order, tracks remaining cards and asks
//             for a reshuffle when a draw hits an empty deck.
//  Revision : 1.0 - initial release
// ============================================================================
module deck_dealer
    import deck_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shuffle_done,
    input  logic              draw_req,
    output logic [CARD_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [CARD_W-1:0] mem_data,
    output logic              draw_ack,
    output logic [CARD_W-1:0] card,
    output logic [3:0]        card_value,
    output logic              card_is_ace,
    output logic [CARD_W-1:0] cards_left,
    output logic              deck_empty,
    output logic              busy,
    output logic              reshuffle_req
);

    logic [1:0]        r_state;
    logic [CARD_W-1:0] r_ptr;
    logic [CARD_W-1:0] r_cards_left;
    logic              r_deck_empty;
    logic [CARD_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_draw_ack;
    logic [CARD_W-1:0] r_card;
    logic [3:0]        r_card_value;
    logic              r_card_is_ace;
    logic              r_busy;
    logic              r_reshuffle_req;

    logic [3:0]        w_lut_value;
    logic              w_lut_is_ace;
    logic [CARD_W-1:0] w_left_next;

    card_value_lut u_lut (
        .i_code   (mem_data),
        .o_value  (w_lut_value),
        .o_is_ace (w_lut_is_ace)
    );

    // CAPTURE is only reachable with at least one card left, so no underflow
    assign w_left_next = r_cards_left - CARD_W'(1);

    // Dealer FSM with counters; every output is registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_EMPTY;
            r_ptr           <= '0;
            r_cards_left    <= '0;
            r_deck_empty    <= 1'b1;
            r_mem_addr      <= '0;
            r_mem_rd        <= 1'b0;
            r_draw_ack      <= 1'b0;
            r_card          <= '0;
            r_card_value    <= 4'd0;
            r_card_is_ace   <= 1'b0;
            r_busy          <= 1'b0;
            r_reshuffle_req <= 1'b0;
        end else begin
            r_draw_ack      <= 1'b0;
            r_reshuffle_req <= 1'b0;
            if (shuffle_done) begin
                // Fresh deck: abort any draw in flight, card outputs untouched
                r_state      <= ST_IDLE;
                r_ptr        <= '0;
                r_cards_left <= CARD_W'(DECK_SIZE);
                r_deck_empty <= 1'b0;
                r_mem_rd     <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (draw_req) begin
                            r_reshuffle_req <= 1'b1;
                        end
                    end
                    ST_IDLE: begin
                        if (draw_req) begin
                            r_state    <= ST_READ;
                            r_mem_addr <= r_ptr;
                            r_mem_rd   <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                    ST_READ: begin
                        r_mem_rd <= 1'b0;
                        r_state  <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        r_card        <= mem_data;
                        r_card_value  <= w_lut_value;
                        r_card_is_ace <= w_lut_is_ace;
                        r_draw_ack    <= 1'b1;
                        r_busy        <= 1'b0;
                        r_ptr         <= r_ptr + CARD_W'(1);
                        r_cards_left  <= w_left_next;
                        r_deck_empty  <= (w_left_next == '0);
                        r_state       <= (w_left_next == '0) ? ST_EMPTY : ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

    assign mem_addr      = r_mem_addr;
    assign mem_rd        = r_mem_rd;
    assign draw_ack      = r_draw_ack;
    assign card          = r_card;
    assign card_value    = r_card_value;
    assign card_is_ace   = r_card_is_ace;
    assign cards_left    = r_cards_left;
    assign deck_empty    = r_deck_empty;
    assign busy          = r_busy;
    assign reshuffle_req = r_reshuffle_req;

endmodule
`default_nettype wire
